// File: rtl/stopwatch_display.sv
// stopwatch_display: MM.SS four-digit seven-segment back-end with serial
// double-dabble conversion, multiplexed digit scan and blink while paused.
module stopwatch_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] status,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       dp_n,
  output logic       min_ovf
);
  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {CONV_IDLE, CONV_SHIFT, CONV_DONE} conv_state_t;

  conv_state_t     state, state_nx;
  logic [7:0]      snap_min;
  logic [5:0]      snap_sec;
  logic [7:0]      snap_sec_ext;
  logic [11:0]     bcd_min, bcd_min_adj;
  logic [7:0]      bcd_sec, bcd_sec_adj;
  logic [2:0]      bit_cnt;
  logic            changed;
  logic [3:0][3:0] digit;
  logic [RW-1:0]   refresh_cnt;
  logic [1:0]      scan_idx;
  logic [BW-1:0]   blink_cnt;
  logic            blink_phase;

  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign changed      = ({minutes, seconds} != {snap_min, snap_sec});
  assign snap_sec_ext = {2'b00, snap_sec};
  assign bcd_min_adj  = {dabble(bcd_min[11:8]), dabble(bcd_min[7:4]), dabble(bcd_min[3:0])};
  assign bcd_sec_adj  = {dabble(bcd_sec[7:4]), dabble(bcd_sec[3:0])};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= CONV_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      CONV_IDLE:  if (changed) state_nx = CONV_SHIFT;
      CONV_SHIFT: if (bit_cnt == 3'd7) state_nx = CONV_DONE;
      CONV_DONE:  state_nx = CONV_IDLE;
      default:    state_nx = CONV_IDLE;
    endcase
  end

  // Conversion datapath; ~bit_cnt selects bits 7 down to 0 across the shifts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_min <= '0;
      snap_sec <= '0;
      bcd_min  <= '0;
      bcd_sec  <= '0;
      bit_cnt  <= '0;
      digit    <= '0;
      min_ovf  <= 1'b0;
    end else begin
      case (state)
        CONV_IDLE: begin
          if (changed) begin
            snap_min <= minutes;
            snap_sec <= seconds;
            bcd_min  <= '0;
            bcd_sec  <= '0;
            bit_cnt  <= '0;
          end
        end
        CONV_SHIFT: begin
          bcd_min <= {bcd_min_adj[10:0], snap_min[~bit_cnt]};
          bcd_sec <= {bcd_sec_adj[6:0], snap_sec_ext[~bit_cnt]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        CONV_DONE: begin
          digit[3] <= bcd_min[7:4];
          digit[2] <= bcd_min[3:0];
          digit[1] <= bcd_sec[7:4];
          digit[0] <= bcd_sec[3:0];
          min_ovf  <= (bcd_min[11:8] != 4'd0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      an_n        <= 4'b1111;
      seg_n       <= 7'b1111111;
      dp_n        <= 1'b1;
    end else begin
      if (refresh_cnt == REFRESH_LAST) begin
        refresh_cnt <= '0;
        scan_idx    <= scan_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end

      if (status == 2'b10) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end

      an_n  <= blink_phase ? 4'b1111 : ~(4'b0001 << scan_idx);
      seg_n <= encode(digit[scan_idx]);
      dp_n  <= blink_phase | (scan_idx != 2'd2);
    end
  end
endmodule

// File: tb/tb_stopwatch_display.sv
// Bench for stopwatch_display: arithmetic reference model checked every cycle,
// plus literal spot checks of displayed digits, overflow and blink recovery.
module tb_stopwatch_display;
  localparam int RDIV = 4;
  localparam int BDIV = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] minutes = 8'd0;
  logic [5:0] seconds = 6'd0;
  logic [1:0] status = 2'b00;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       dp_n;
  logic       min_ovf;

  stopwatch_display #(.REFRESH_DIV(RDIV), .BLINK_DIV(BDIV)) dut (
    .clk(clk), .rst_n(rst_n), .minutes(minutes), .seconds(seconds),
    .status(status), .seg_n(seg_n), .an_n(an_n), .dp_n(dp_n), .min_ovf(min_ovf)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [6:0] enc_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  // Reference model: time since reset selects the digit, consecutive paused
  // clocks set the blink phase, and a conversion is a 9-clock busy window
  // after which the captured value appears as decimal digits.
  int         m_snap, m_timer, m_scan, m_pause, m_idx, m_min, m_sec;
  int         m_dig [4];
  bit         m_ph, m_ovf, started;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  always @(posedge clk) begin
    started = 1'b1;
    if (!rst_n) begin
      m_snap = 0; m_timer = 0; m_scan = 0; m_pause = 0; m_ovf = 1'b0;
      for (int i = 0; i < 4; i++) m_dig[i] = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      m_idx = (m_scan / RDIV) % 4;
      m_ph  = ((m_pause / BDIV) % 2) == 1;
      e_an  = m_ph ? 4'hF : ~(4'b0001 << m_idx);
      e_seg = enc_tab[m_dig[m_idx]];
      e_dp  = m_ph || (m_idx != 2);
      m_scan  = (m_scan + 1) % (4 * RDIV);
      m_pause = (status == 2'b10) ? (m_pause + 1) % (2 * BDIV) : 0;
      if (m_timer == 0) begin
        if (int'({minutes, seconds}) != m_snap) begin
          m_snap  = int'({minutes, seconds});
          m_timer = 9;
        end
      end else begin
        m_timer--;
        if (m_timer == 0) begin
          m_min = m_snap / 64;
          m_sec = m_snap % 64;
          m_dig[3] = (m_min % 100) / 10;
          m_dig[2] = m_min % 10;
          m_dig[1] = m_sec / 10;
          m_dig[0] = m_sec % 10;
          m_ovf    = m_min >= 100;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("an_n", 32'(an_n), 32'(e_an));
      check("seg_n", 32'(seg_n), 32'(e_seg));
      check("dp_n", 32'(dp_n), 32'(e_dp));
      check("min_ovf", 32'(min_ovf), 32'(m_ovf));
    end
  end

  // Wait (bounded) until the given anode is active, then pin its segments.
  task automatic lit_digit(input string name, input logic [3:0] an, input logic [6:0] seg);
    bit found = 1'b0;
    for (int k = 0; k < 8 * RDIV + 4 && !found; k++) begin
      @(negedge clk);
      if (an_n == an) found = 1'b1;
    end
    if (found) check(name, 32'(seg_n), 32'(seg));
    else       check({name, "_timeout"}, 32'(an_n), 32'(an));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit found;
    cycles(3);
    check("rst_an", 32'(an_n), 32'hF);
    check("rst_seg", 32'(seg_n), 32'h7F);
    rst_n = 1'b1;

    lit_digit("idle_d2", 4'b1011, 7'b1000000);
    check("idle_dp", 32'(dp_n), 32'h0);

    status = 2'b01; minutes = 8'd12; seconds = 6'd59;
    cycles(12);
    lit_digit("d_12_59_m10", 4'b0111, 7'b1111001);
    lit_digit("d_12_59_m1", 4'b1011, 7'b0100100);
    lit_digit("d_12_59_s10", 4'b1101, 7'b0010010);
    lit_digit("d_12_59_s1", 4'b1110, 7'b0010000);
    check("ovf_12", 32'(min_ovf), 32'h0);

    minutes = 8'd123; seconds = 6'd0;
    cycles(12);
    lit_digit("d_123_m10", 4'b0111, 7'b0100100);
    lit_digit("d_123_m1", 4'b1011, 7'b0110000);
    lit_digit("d_123_s1", 4'b1110, 7'b1000000);
    check("ovf_123", 32'(min_ovf), 32'h1);

    minutes = 8'd99;
    cycles(12);
    lit_digit("d_99_m10", 4'b0111, 7'b0010000);
    check("ovf_99", 32'(min_ovf), 32'h0);

    seconds = 6'd5;
    cycles(3);
    seconds = 6'd6;
    cycles(25);
    lit_digit("d_mid_s1", 4'b1110, 7'b0000010);

    status = 2'b10;
    cycles(3 * BDIV + 3);
    found = 1'b0;
    for (int k = 0; k < 4 * BDIV && !found; k++) begin
      @(negedge clk);
      if (an_n == 4'hF) found = 1'b1;
    end
    check("blank_seen", 32'(found), 32'h1);
    status = 2'b01;
    cycles(2);
    check("unblank", 32'(an_n != 4'hF), 32'h1);

    minutes = 8'd45; seconds = 6'd30;
    cycles(4);
    rst_n = 1'b0;
    cycles(1);
    check("rst_mid_an", 32'(an_n), 32'hF);
    check("rst_mid_ovf", 32'(min_ovf), 32'h0);
    rst_n = 1'b1;
    cycles(12);
    lit_digit("d_45_m10", 4'b0111, 7'b0011001);

    for (int it = 0; it < 200; it++) begin
      minutes = 8'($urandom_range(0, 255));
      seconds = 6'($urandom_range(0, 63));
      status  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        cycles(int'($urandom_range(1, 2)));
        rst_n = 1'b1;
      end
      cycles(int'($urandom_range(1, 30)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
